// File: rtl/monolith_merkle_root.sv
// Merkle-root sequencer in front of the Monolith permutation engine.
// Hashes each leaf, then compresses pairs in place until one node remains.
module monolith_merkle_root #(
  parameter int LEAVES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        leaf_valid,
  output logic        leaf_ready,
  input  logic [30:0] leaf_data,
  output logic        root_valid,
  input  logic        root_ready,
  output logic [30:0] root,
  output logic        busy,
  output logic [30:0] eng_in1,
  output logic [30:0] eng_in2,
  output logic        eng_hash_or_compress,
  output logic        eng_go,
  input  logic [30:0] eng_out,
  input  logic        eng_valid
);

  if (LEAVES < 2 || LEAVES > 16 || (LEAVES & (LEAVES - 1)) != 0) begin : g_bad
    $fatal(1, "LEAVES must be a power of two in 2..16");
  end

  localparam int IW = $clog2(LEAVES);
  localparam int CW = IW + 1;

  typedef enum logic [2:0] {
    LEAF_WAIT,
    HASH,
    COMP,
    GAP,
    ROOT
  } state_t;

  state_t        state, state_nxt;
  logic [30:0]   nodes [LEAVES];
  logic [IW-1:0] leaf_idx;
  logic [CW-1:0] n, j, n_nxt, j_nxt;
  logic          hashing;
  logic [IW-1:0] lo_addr, hi_addr;
  logic [30:0]   leaf_red;

  assign leaf_red = (leaf_data == 31'h7FFF_FFFF) ? '0 : leaf_data;
  assign lo_addr  = IW'({j_nxt, 1'b0});
  assign hi_addr  = lo_addr | IW'(1);
  assign root     = root_valid ? nodes[0] : '0;

  always_comb begin
    state_nxt  = state;
    leaf_ready = 1'b0;
    eng_go     = 1'b0;
    root_valid = 1'b0;
    n_nxt      = n;
    j_nxt      = j;
    unique case (state)
      LEAF_WAIT: begin
        leaf_ready = 1'b1;
        if (leaf_valid) state_nxt = HASH;
      end
      HASH, COMP: begin
        eng_go = 1'b1;
        if (eng_valid) state_nxt = GAP;
      end
      GAP: begin
        if (hashing && leaf_idx != IW'(LEAVES - 1)) begin
          state_nxt = LEAF_WAIT;
        end else begin
          if (hashing) begin
            n_nxt = CW'(LEAVES / 2);
            j_nxt = '0;
          end else begin
            j_nxt = j + 1'b1;
            if (j_nxt == n) begin
              n_nxt = n >> 1;
              j_nxt = '0;
            end
          end
          state_nxt = (n_nxt == '0) ? ROOT : COMP;
        end
      end
      ROOT: begin
        root_valid = 1'b1;
        if (root_ready) state_nxt = LEAF_WAIT;
      end
      default: state_nxt = LEAF_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= LEAF_WAIT;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LEAVES; i++) nodes[i] <= '0;
      leaf_idx             <= '0;
      n                    <= '0;
      j                    <= '0;
      hashing              <= 1'b1;
      busy                 <= 1'b0;
      eng_in1              <= '0;
      eng_in2              <= '0;
      eng_hash_or_compress <= 1'b0;
    end else begin
      unique case (state)
        LEAF_WAIT: if (leaf_valid) begin
          eng_in1              <= leaf_red;
          eng_in2              <= '0;
          eng_hash_or_compress <= 1'b0;
          hashing              <= 1'b1;
          busy                 <= 1'b1;
        end
        HASH: if (eng_valid) nodes[leaf_idx] <= eng_out;
        // pair j always lands at slot j, so the tree shrinks in place
        COMP: if (eng_valid) nodes[j[IW-1:0]] <= eng_out;
        GAP: begin
          if (state_nxt == LEAF_WAIT) begin
            leaf_idx <= leaf_idx + 1'b1;
          end else begin
            n       <= n_nxt;
            j       <= j_nxt;
            hashing <= 1'b0;
            if (state_nxt == COMP) begin
              eng_in1              <= nodes[lo_addr];
              eng_in2              <= nodes[hi_addr];
              eng_hash_or_compress <= 1'b1;
            end
          end
        end
        ROOT: if (root_ready) begin
          leaf_idx <= '0;
          n        <= '0;
          j        <= '0;
          hashing  <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_monolith_merkle_root.sv
// Directed bench for monolith_merkle_root with an L=3 engine stub:
// hash(x)=x+1, compress(a,b)=a+2b, both mod 2^31-1.
module tb_monolith_merkle_root;

  localparam logic [30:0] P = 31'h7FFF_FFFF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        leaf_valid [2];
  logic        leaf_ready [2];
  logic [30:0] leaf_data  [2];
  logic        root_valid [2];
  logic        root_ready [2];
  logic [30:0] root       [2];
  logic        busy       [2];
  logic [30:0] in1        [2];
  logic [30:0] in2        [2];
  logic        mode       [2];
  logic        go         [2];
  logic [30:0] eout       [2];
  logic        ev         [2];

  monolith_merkle_root #(.LEAVES(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .leaf_valid(leaf_valid[0]), .leaf_ready(leaf_ready[0]),
    .leaf_data(leaf_data[0]),
    .root_valid(root_valid[0]), .root_ready(root_ready[0]),
    .root(root[0]), .busy(busy[0]),
    .eng_in1(in1[0]), .eng_in2(in2[0]),
    .eng_hash_or_compress(mode[0]), .eng_go(go[0]),
    .eng_out(eout[0]), .eng_valid(ev[0])
  );

  monolith_merkle_root #(.LEAVES(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .leaf_valid(leaf_valid[1]), .leaf_ready(leaf_ready[1]),
    .leaf_data(leaf_data[1]),
    .root_valid(root_valid[1]), .root_ready(root_ready[1]),
    .root(root[1]), .busy(busy[1]),
    .eng_in1(in1[1]), .eng_in2(in2[1]),
    .eng_hash_or_compress(mode[1]), .eng_go(go[1]),
    .eng_out(eout[1]), .eng_valid(ev[1])
  );

  logic [2:0]  cnt     [2];
  logic        v       [2];
  logic        sp      [2];
  logic        sm      [2];
  logic        spur_en [2];
  logic [30:0] res     [2];

  function automatic logic [30:0] fm(input logic [33:0] s);
    return 31'(s % 34'(P));
  endfunction

  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      sp[k] <= spur_en[k] & v[k];
      if (!go[k]) begin
        cnt[k] <= '0;
        v[k]   <= 1'b0;
      end else begin
        cnt[k] <= cnt[k] + 3'd1;
        v[k]   <= (cnt[k] == 3'd2);
        res[k] <= mode[k]
          ? fm({3'b0, in1[k]} + {2'b0, in2[k], 1'b0})
          : fm({3'b0, in1[k]} + 34'd1);
      end
    end

  always_comb
    for (int k = 0; k < 2; k++) begin
      ev[k]   = v[k] | sp[k] | sm[k];
      eout[k] = (sp[k] | sm[k]) ? 31'h05A5_A5A5 : res[k];
    end

  // request-discipline monitor on the 4-leaf instance
  int          rises = 0, bad_gap = 0, bad_stab = 0, bad_in2 = 0;
  int          lowrun = 0;
  logic        pgo = 1'b0;
  logic [62:0] snap = '0;

  always @(negedge clk) begin
    if (go[0] && !pgo) begin
      rises++;
      if (mode[0] && lowrun != 1) bad_gap++;
    end
    if (go[0] && pgo && {in1[0], in2[0], mode[0]} != snap) bad_stab++;
    if (go[0] && !mode[0] && in2[0] != '0) bad_in2++;
    lowrun = go[0] ? 0 : lowrun + 1;
    pgo    = go[0];
    snap   = {in1[0], in2[0], mode[0]};
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic send_leaf(input int k, input logic [30:0] d);
    int t;
    t = 0;
    leaf_valid[k] = 1'b1;
    leaf_data[k]  = d;
    while (!leaf_ready[k] && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 300) begin
      n_bad++;
      $display("FAIL leaf_accept k=%0d: got no leaf_ready, want leaf_ready", k);
    end
    @(negedge clk);
    leaf_valid[k] = 1'b0;
  endtask

  task automatic wait_root(input int k);
    int t;
    t = 0;
    while (!root_valid[k] && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 500) begin
      n_bad++;
      $display("FAIL root_timeout k=%0d: got no root_valid, want root_valid", k);
    end
  endtask

  task automatic release_root(input int k);
    root_ready[k] = 1'b1;
    @(negedge clk);
    root_ready[k] = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 9;
    if (leaf_ready[0] !== 1'b1) begin n_bad++; $display("FAIL rst_leaf_ready: got %b want 1", leaf_ready[0]); end
    if (root_valid[0] !== 1'b0) begin n_bad++; $display("FAIL rst_root_valid: got %b want 0", root_valid[0]); end
    if (root[0] !== 31'd0) begin n_bad++; $display("FAIL rst_root: got %h want 0", root[0]); end
    if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy[0]); end
    if (go[0] !== 1'b0) begin n_bad++; $display("FAIL rst_go: got %b want 0", go[0]); end
    if (in1[0] !== 31'd0) begin n_bad++; $display("FAIL rst_in1: got %h want 0", in1[0]); end
    if (in2[0] !== 31'd0) begin n_bad++; $display("FAIL rst_in2: got %h want 0", in2[0]); end
    if (mode[0] !== 1'b0) begin n_bad++; $display("FAIL rst_mode: got %b want 0", mode[0]); end
    if (leaf_ready[1] !== 1'b1) begin n_bad++; $display("FAIL rst_leaf_ready2: got %b want 1", leaf_ready[1]); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_tree;
    int r0, g0, s0, i0;
    r0 = rises; g0 = bad_gap; s0 = bad_stab; i0 = bad_in2;
    root_ready[0] = 1'b0;
    send_leaf(0, 31'd1);
    send_leaf(0, 31'd2);
    send_leaf(0, 31'd3);
    send_leaf(0, 31'd4);
    wait_root(0);
    n_cmp += 7;
    if (root[0] !== 31'd36) begin n_bad++; $display("FAIL basic_root: got %0d want 36", root[0]); end
    if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy[0]); end
    if (leaf_ready[0] !== 1'b0) begin n_bad++; $display("FAIL basic_leaf_ready: got %b want 0", leaf_ready[0]); end
    if (rises - r0 !== 7) begin n_bad++; $display("FAIL go_rises: got %0d want 7", rises - r0); end
    if (bad_gap - g0 !== 0) begin n_bad++; $display("FAIL go_gap: got %0d bad gaps want 0", bad_gap - g0); end
    if (bad_stab - s0 !== 0) begin n_bad++; $display("FAIL op_stable: got %0d changes want 0", bad_stab - s0); end
    if (bad_in2 - i0 !== 0) begin n_bad++; $display("FAIL hash_in2: got %0d nonzero want 0", bad_in2 - i0); end
  endtask

  task automatic test_root_backpressure;
    leaf_valid[0] = 1'b1;
    leaf_data[0]  = 31'd99;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp += 3;
      if (root[0] !== 31'd36) begin n_bad++; $display("FAIL bp_root c%0d: got %0d want 36", i, root[0]); end
      if (root_valid[0] !== 1'b1) begin n_bad++; $display("FAIL bp_root_valid c%0d: got %b want 1", i, root_valid[0]); end
      if (leaf_ready[0] !== 1'b0) begin n_bad++; $display("FAIL bp_leaf_ready c%0d: got %b want 0", i, leaf_ready[0]); end
    end
    n_cmp += 2;
    if (go[0] !== 1'b0) begin n_bad++; $display("FAIL bp_go: got %b want 0", go[0]); end
    if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL bp_busy: got %b want 1", busy[0]); end
    leaf_valid[0] = 1'b0;
    root_ready[0] = 1'b1;
    @(negedge clk);
    root_ready[0] = 1'b0;
    n_cmp += 3;
    if (leaf_ready[0] !== 1'b1) begin n_bad++; $display("FAIL post_leaf_ready: got %b want 1", leaf_ready[0]); end
    if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL post_busy: got %b want 0", busy[0]); end
    if (root_valid[0] !== 1'b0) begin n_bad++; $display("FAIL post_root_valid: got %b want 0", root_valid[0]); end
  endtask

  task automatic test_canonical_reduction;
    root_ready[1] = 1'b1;
    send_leaf(1, P);
    n_cmp += 3;
    if (go[1] !== 1'b1) begin n_bad++; $display("FAIL red_go: got %b want 1", go[1]); end
    if (in1[1] !== 31'd0) begin n_bad++; $display("FAIL red_in1: got %h want 0", in1[1]); end
    if (mode[1] !== 1'b0) begin n_bad++; $display("FAIL red_mode: got %b want 0", mode[1]); end
    send_leaf(1, 31'd5);
    n_cmp++;
    if (in1[1] !== 31'd5) begin n_bad++; $display("FAIL red_in1_b: got %h want 5", in1[1]); end
    wait_root(1);
    n_cmp++;
    if (root[1] !== 31'd13) begin n_bad++; $display("FAIL red_root: got %0d want 13", root[1]); end
    @(negedge clk);
    root_ready[1] = 1'b0;
    n_cmp += 2;
    if (root_valid[1] !== 1'b0) begin n_bad++; $display("FAIL early_ready: got %b want 0", root_valid[1]); end
    if (busy[1] !== 1'b0) begin n_bad++; $display("FAIL red_busy: got %b want 0", busy[1]); end
  endtask

  task automatic test_reset_mid_compress;
    int   c, t;
    logic p;
    c = 0; t = 0; p = go[0];
    send_leaf(0, 31'd1);
    send_leaf(0, 31'd2);
    send_leaf(0, 31'd3);
    send_leaf(0, 31'd4);
    p = go[0];
    while (c < 2 && t < 500) begin
      @(negedge clk);
      t++;
      if (go[0] && !p && mode[0]) c++;
      p = go[0];
    end
    n_cmp++;
    if (c < 2) begin n_bad++; $display("FAIL comp2_seen: got %0d comps want 2", c); end
    #1 reset_n = 1'b0;
    #1;
    n_cmp += 8;
    if (go[0] !== 1'b0) begin n_bad++; $display("FAIL mid_go: got %b want 0", go[0]); end
    if (leaf_ready[0] !== 1'b1) begin n_bad++; $display("FAIL mid_leaf_ready: got %b want 1", leaf_ready[0]); end
    if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy[0]); end
    if (root_valid[0] !== 1'b0) begin n_bad++; $display("FAIL mid_root_valid: got %b want 0", root_valid[0]); end
    if (root[0] !== 31'd0) begin n_bad++; $display("FAIL mid_root: got %h want 0", root[0]); end
    if (in1[0] !== 31'd0) begin n_bad++; $display("FAIL mid_in1: got %h want 0", in1[0]); end
    if (in2[0] !== 31'd0) begin n_bad++; $display("FAIL mid_in2: got %h want 0", in2[0]); end
    if (mode[0] !== 1'b0) begin n_bad++; $display("FAIL mid_mode: got %b want 0", mode[0]); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_leaf(0, 31'd1);
    send_leaf(0, 31'd2);
    send_leaf(0, 31'd3);
    send_leaf(0, 31'd4);
    wait_root(0);
    n_cmp++;
    if (root[0] !== 31'd36) begin n_bad++; $display("FAIL rerun_root: got %0d want 36", root[0]); end
    release_root(0);
  endtask

  task automatic test_spurious;
    int t;
    spur_en[0] = 1'b1;
    sm[0] = 1'b1;
    @(negedge clk);
    sm[0] = 1'b0;
    n_cmp += 2;
    if (leaf_ready[0] !== 1'b1) begin n_bad++; $display("FAIL spur_wait_ready: got %b want 1", leaf_ready[0]); end
    if (go[0] !== 1'b0) begin n_bad++; $display("FAIL spur_wait_go: got %b want 0", go[0]); end
    send_leaf(0, 31'd1);
    send_leaf(0, 31'd2);
    t = 0;
    while (!leaf_ready[0] && t < 300) begin
      @(negedge clk);
      t++;
    end
    sm[0] = 1'b1;
    @(negedge clk);
    sm[0] = 1'b0;
    send_leaf(0, 31'd3);
    send_leaf(0, 31'd4);
    wait_root(0);
    n_cmp++;
    if (root[0] !== 31'd36) begin n_bad++; $display("FAIL spur_root: got %0d want 36", root[0]); end
    release_root(0);
    spur_en[0] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      leaf_valid[k] = 1'b0;
      leaf_data[k]  = '0;
      root_ready[k] = 1'b0;
      spur_en[k]    = 1'b0;
      sm[k]         = 1'b0;
    end
    test_reset;
    test_basic_tree;
    test_root_backpressure;
    test_canonical_reduction;
    test_reset_mid_compress;
    test_spurious;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog");
  end

endmodule
